// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op codes, FSM states, alignment rules.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } state_e;

  localparam logic [1:0] MASK_WORD = 2'b11;
  localparam logic [1:0] MASK_HALF = 2'b01;

  function automatic logic [1:0] align_mask(op_e op);
    logic [1:0] m;
    m = 2'b00;
    unique case (1'b1)
      (op == OP_LW) || (op == OP_SW): m = MASK_WORD;
      (op == OP_LH) || (op == OP_LHU) || (op == OP_SH): m = MASK_HALF;
      default: m = 2'b00;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(op_e op, logic [1:0] a);
    return |(a & align_mask(op));
  endfunction

  function automatic logic is_store(op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and store lane merge.
module lsu_align
  import lsu_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_ld_word,
  input  logic [31:0] i_st_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_ld_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_ld_word[31:16]
                           : i_ld_word[15:0];

  always_comb begin
    o_rdata = 32'd0;
    unique case (1'b1)
      i_op == OP_LW:  o_rdata = i_ld_word;
      i_op == OP_LH:  o_rdata = {{16{w_half[15]}}, w_half};
      i_op == OP_LHU: o_rdata = {16'd0, w_half};
      i_op == OP_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
      i_op == OP_LBU: o_rdata = {24'd0, w_byte};
      default:        o_rdata = 32'd0;
    endcase
  end

  always_comb begin
    o_wdata = i_st_word;
    unique case (1'b1)
      i_op == OP_SW: o_wdata = i_wdata;
      i_op == OP_SH: o_wdata[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      i_op == OP_SB: o_wdata[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      default:       o_wdata = i_st_word;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit FSM with read-modify-write for sub-word stores.
// Optional store trace: define LSU_TRACE_EN.
module lsu_rmw
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      r_state;
  op_e         r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  op_e         w_req_op;
  logic [31:0] w_ld_data;
  logic [31:0] w_st_data;

  assign w_req_op = op_e'(req_op);

  lsu_align u_align (
    .i_op      (r_op),
    .i_off     (r_addr[1:0]),
    .i_ld_word (mem_rdata),
    .i_st_word (r_word),
    .i_wdata   (r_wdata),
    .o_rdata   (w_ld_data),
    .o_wdata   (w_st_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_LW;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_pc    <= 32'd0;
      r_word  <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= w_req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_pc    <= req_pc;
            r_err   <= 1'b0;
            if (is_misaligned(w_req_op, req_addr[1:0])) begin
              r_err   <= 1'b1;
              r_rdata <= 32'd0;
              r_state <= S_RESP;
            end else if (w_req_op == OP_SW) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_word <= mem_rdata;
          if (is_store(r_op)) begin
            r_state <= S_WR;
          end else begin
            r_rdata <= w_ld_data;
            r_state <= S_RESP;
          end
        end
        S_WR: begin
          r_rdata <= 32'd0;
          r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = r_rdata;
  assign mem_en    = (r_state == S_RD_REQ) || (r_state == S_WR);
  assign mem_we    = (r_state == S_WR);
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = (r_state == S_WR) ? w_st_data : 32'd0;

`ifdef LSU_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_WR)
      $display("@%h: *%h <= %h", r_pc, r_addr, mem_wdata);
  end
`else
  // The PC only feeds the trace.
  logic w_unused_pc;
  assign w_unused_pc = ^r_pc;
`endif

endmodule
